// File: rtl/sram_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and a single-port SRAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned DATA_W = 32;

    logic              p0_req;
    logic              p0_we;
    logic [1:0]        p0_size;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [1:0]        p1_size;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    modport slave (
        input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output sram_w_en, sram_address, sram_write_data,
        input  sram_read_data
    );

    modport master (
        output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  sram_w_en, sram_address, sram_write_data,
        output sram_read_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM: one access per cycle, one-cycle response.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution; otherwise p1 always wins.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic clk,
    input  logic rst,
    sram_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_BAD  = 2'b11;

    logic              gnt0_c;
    logic              gnt1_c;
    logic              any_gnt_c;
    logic              sel_we_c;
    logic [1:0]        sel_size_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              illegal_c;
    logic [3:0]        w_en_c;

    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              err0_q;
    logic              err1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef SRAM_ARB_RR_EN
    // Set when p1 won the most recent conflict; only conflict cycles move it.
    logic last_p1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_p1_q <= 1'b1;
        end else if (bus.p0_req && bus.p1_req) begin
            last_p1_q <= gnt1_c;
        end
    end
`endif

    // Grant selection; nothing is granted while in reset.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (bus.p0_req && bus.p1_req) begin
`ifdef SRAM_ARB_RR_EN
                gnt0_c = last_p1_q;
                gnt1_c = !last_p1_q;
`else
                gnt1_c = 1'b1;
`endif
            end else begin
                gnt0_c = bus.p0_req;
                gnt1_c = bus.p1_req;
            end
        end
    end

    // Winner's request fields; zero when idle.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_size_c  = SIZE_BYTE;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (gnt1_c) begin
            sel_we_c    = bus.p1_we;
            sel_size_c  = bus.p1_size;
            sel_addr_c  = bus.p1_addr;
            sel_wdata_c = bus.p1_wdata;
        end else if (gnt0_c) begin
            sel_we_c    = bus.p0_we;
            sel_size_c  = bus.p0_size;
            sel_addr_c  = bus.p0_addr;
            sel_wdata_c = bus.p0_wdata;
        end
    end

    assign any_gnt_c = gnt0_c || gnt1_c;
    assign illegal_c = any_gnt_c && (sel_size_c == SIZE_BAD);

    // Byte-lane write enables; illegal sizes and reads write nothing.
    always_comb begin
        w_en_c = 4'b0000;
        if (any_gnt_c && sel_we_c) begin
            case (sel_size_c)
                SIZE_BYTE: w_en_c = 4'b0001;
                SIZE_HALF: w_en_c = 4'b0011;
                SIZE_WORD: w_en_c = 4'b1111;
                default:   w_en_c = 4'b0000;
            endcase
        end
    end

    // Response registers: capture pre-write SRAM data for whichever port won.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0_c;
            rvalid1_q <= gnt1_c;
            err0_q    <= gnt0_c && illegal_c;
            err1_q    <= gnt1_c && illegal_c;
            if (gnt0_c) begin
                rdata0_q <= illegal_c ? '0 : bus.sram_read_data;
            end
            if (gnt1_c) begin
                rdata1_q <= illegal_c ? '0 : bus.sram_read_data;
            end
        end
    end

    assign bus.p0_gnt          = gnt0_c;
    assign bus.p1_gnt          = gnt1_c;
    assign bus.sram_w_en       = w_en_c;
    assign bus.sram_address    = sel_addr_c;
    assign bus.sram_write_data = sel_wdata_c;

    // Masked by rst so a response landing as reset asserts is dropped immediately.
    assign bus.p0_rvalid = rvalid0_q && !rst;
    assign bus.p1_rvalid = rvalid1_q && !rst;
    assign bus.p0_err    = err0_q && !rst;
    assign bus.p1_err    = err1_q && !rst;
    assign bus.p0_rdata  = rst ? '0 : rdata0_q;
    assign bus.p1_rdata  = rst ? '0 : rdata1_q;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: byte-address width, which SHALL match the SRAM address width.
REQ-002 The block SHALL have port clk, input, 1: the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have ports pN_req (N=0,1), input, 1: port N requests an access; held high until granted.
REQ-005 The block SHALL have ports pN_we, input, 1: 1 means write, 0 means read.
REQ-006 The block SHALL have ports pN_size, input, 2: access size; 00 is byte, 01 is half, 10 is word, 11 is illegal.
REQ-007 The block SHALL have ports pN_addr, input, ADDR_W: byte address.
REQ-008 The block SHALL have ports pN_wdata, input, 32: write data, LSB-aligned.
REQ-009 The block SHALL have ports pN_gnt, output, 1: combinational grant; the request is consumed this cycle.
REQ-010 The block SHALL have ports pN_rvalid, output, 1: registered response strobe, one cycle after the grant.
REQ-011 The block SHALL have ports pN_rdata, output, 32: registered read data, valid while pN_rvalid is high.
REQ-012 The block SHALL have ports pN_err, output, 1: the response is for an illegal size; qualified by pN_rvalid.
REQ-013 The block SHALL have port sram_w_en, output, 4: SRAM write-enable code.
REQ-014 The block SHALL have port sram_address, output, ADDR_W: SRAM byte address.
REQ-015 The block SHALL have port sram_write_data, output, 32: SRAM write data.
REQ-016 The block SHALL have port sram_read_data, input, 32: SRAM combinational read data.

Function
REQ-017 The block SHALL grant at most one port per cycle; pN_gnt SHALL be high only when pN_req is high and the block is not in reset.
REQ-018 When only one port requests, the block SHALL grant that port in the same cycle, with no bubble.
REQ-019 When both ports request, the block SHALL grant according to the policy in Configuration; the loser's gnt SHALL stay 0 and it keeps requesting.
REQ-020 In a granted cycle, the block SHALL drive sram_address equal to the winner's addr, unmodified; address wrap past the top of memory is left to the SRAM.
REQ-021 In a granted cycle, the block SHALL drive sram_write_data equal to the winner's wdata.
REQ-022 For a granted write, sram_w_en SHALL be 4'b0001 for size 00, 4'b0011 for size 01, and 4'b1111 for size 10.
REQ-023 For a granted read, an illegal size, or an idle cycle, sram_w_en SHALL be 4'b0000.
REQ-024 In an idle cycle, sram_address and sram_write_data SHALL be 0.
REQ-025 On the edge ending a grant cycle, the block SHALL register sram_read_data into the winner's rdata, for reads and writes alike; for writes the captured value is the pre-write contents.
REQ-026 The winner's rvalid SHALL be high for exactly one cycle after that edge; rdata SHALL hold its value until that port's next response.
REQ-027 An illegal size SHALL still be granted, SHALL write nothing, and SHALL return rvalid=1, err=1, rdata=0.
REQ-028 Misaligned addresses SHALL be legal and passed through unchanged.
REQ-029 Back-to-back grants SHALL be allowed; a read granted in the cycle after a write to the same address SHALL return the new data.
REQ-030 The block SHALL contain no FSM beyond the priority pointer and the response registers; throughput SHALL be one access per cycle.

Reset
REQ-031 While rst is high, all gnt, rvalid, err and sram_w_en SHALL be 0, and sram_address and sram_write_data SHALL be 0.
REQ-032 Reset SHALL clear rdata to 0 and set the priority pointer to "p1 last", so that p0 wins the first conflict under the round-robin policy.
REQ-033 When rst is asserted mid-stream, a response due on the next cycle SHALL be dropped, with rvalid 0.

Configuration
REQ-034 With SRAM_ARB_RR_EN defined, the block SHALL arbitrate conflicts round-robin: the port not granted at the last conflict wins, and the pointer updates only on conflict cycles.
REQ-035 Without SRAM_ARB_RR_EN, p1 SHALL always win conflicts (fixed priority), and the pointer SHALL be absent.

Verification
REQ-036 The bench SHALL cover: p1 write, word, addr 0x0010, data 0xDEADBEEF -> w_en 1111; then p0 read of 0x0010 -> rvalid next cycle, rdata 0xDEADBEEF.
REQ-037 The bench SHALL cover: p1 writes, half 0xAAAA5678 then byte 0x000000FF, to 0x0020 over a word 0x11223344 -> w_en 0011 then 0001; a read returns 0x112256FF.
REQ-038 The bench SHALL cover: both ports reading continuously for 4 cycles -> with RR, grants p0, p1, p0, p1; without RR, p1 is granted all 4 cycles.
REQ-039 The bench SHALL cover: p0 request with size 11 and we=1 -> w_en 0000, memory unchanged, and next cycle p0_rvalid=1, p0_err=1, p0_rdata=0.
REQ-040 The bench SHALL cover: rst asserted in the cycle after a p1 read grant -> p1_rvalid stays 0, and all outputs are 0 while rst is held.
REQ-041 The bench SHALL cover: word write to 0xFFFE with 0x01020304 -> a word read at 0xFFFE returns 0x01020304 (address wraps in the SRAM).
